// File: rtl/cu_pkg.sv
// Shared types and constants for the 3-stage DLX-style hardwired control unit.
package cu_pkg;

    // Opcodes (6-bit)
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SUBI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_NOP   = 6'h15;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (low 6 bits of func)
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    // Control word, MSB first in the same order as the datapath stages
    typedef struct packed {
        logic    rf1;
        logic    rf2;
        logic    en1;
        logic    s1;
        logic    s2;
        alu_op_t alu;
        logic    en2;
        logic    rm;
        logic    wm;
        logic    en3;
        logic    s3;
        logic    wf1;
    } cw_t;

    typedef enum logic [1:0] {
        ST1 = 2'd0,
        ST2 = 2'd1,
        ST3 = 2'd2
    } state_t;

    // Build the common ALU-instruction control word with a chosen B source and op
    function automatic cw_t alu_cw(input logic rf2, input logic s2, input alu_op_t op);
        cw_t cw;
        cw     = '0;
        cw.rf1 = 1'b1;
        cw.rf2 = rf2;
        cw.s2  = s2;
        cw.alu = op;
        cw.en2 = 1'b1;
        cw.en3 = 1'b1;
        cw.wf1 = 1'b1;
        return cw;
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode/func -> 13-bit control word lookup.
module cu_decoder
    import cu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output cw_t        cw
);

    // Table lookup; anything not listed (including NOP) yields an all-zero word
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cw = '0;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (func)
                    FN_ADD:  cw = alu_cw(1'b1, 1'b0, ALU_ADD);
                    FN_SUB:  cw = alu_cw(1'b1, 1'b0, ALU_SUB);
                    FN_AND:  cw = alu_cw(1'b1, 1'b0, ALU_AND);
                    FN_OR:   cw = alu_cw(1'b1, 1'b0, ALU_OR);
                    default: cw = '0;
                endcase
            end
            OP_ADDI: cw = alu_cw(1'b0, 1'b1, ALU_ADD);
            OP_SUBI: cw = alu_cw(1'b0, 1'b1, ALU_SUB);
            OP_ANDI: cw = alu_cw(1'b0, 1'b1, ALU_AND);
            OP_ORI:  cw = alu_cw(1'b0, 1'b1, ALU_OR);
            OP_LW: begin
                cw    = alu_cw(1'b0, 1'b1, ALU_ADD);
                cw.rm = 1'b1;
                cw.s3 = 1'b1;
            end
            OP_SW: begin
                cw     = alu_cw(1'b1, 1'b1, ALU_ADD);
                cw.wm  = 1'b1;
                cw.wf1 = 1'b0;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/cu_fsm.sv
// Hardwired 3-state control unit: stage-1 bits come straight from the decoder,
// the full word is latched leaving ST1 and replayed stage by stage in ST2/ST3.
module cu_fsm
    import cu_pkg::*;
#(
    parameter int FUNC_SIZE    = 11,
    parameter int OP_CODE_SIZE = 6,
    parameter int CW_SIZE      = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OP_CODE_SIZE-1:0] opcode,
    input  logic [FUNC_SIZE-1:0]    func,
    output logic                    rf1,
    output logic                    rf2,
    output logic                    en1,
    output logic                    s1,
    output logic                    s2,
    output logic                    alu1,
    output logic                    alu2,
    output logic                    en2,
    output logic                    rm,
    output logic                    wm,
    output logic                    en3,
    output logic                    s3,
    output logic                    wf1
);

    state_t state_q, state_d;
    cw_t    cw_q, cw_d;
    cw_t    dec_cw;
    cw_t    out_cw;

    // Upper func bits and CW_SIZE are deliberately ignored
    logic unused_bits;
    assign unused_bits = (^func[FUNC_SIZE-1:6]) ^ (CW_SIZE != 0);

    cu_decoder u_dec (
        .opcode (opcode[5:0]),
        .func   (func[5:0]),
        .cw     (dec_cw)
    );

    // Next state: fixed ST1->ST2->ST3 ring; capture the decoded word leaving ST1
    always_comb begin
        state_d = ST1;
        cw_d    = cw_q;
        unique case (state_q)
            ST1: begin
                state_d = ST2;
                cw_d    = dec_cw;
            end
            ST2:     state_d = ST3;
            ST3:     state_d = ST1;
            default: state_d = ST1;
        endcase
    end

    // State and control-word registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; always_comb blocks use blocking.
        if (rst) begin
            state_q <= ST1;
            cw_q    <= '0;
        end else begin
            state_q <= state_d;
            cw_q    <= cw_d;
        end
    end

    // Per-state masking: only the active stage's bits leave the unit; reset blanks all
    always_comb begin
        out_cw = '0;
        if (!rst) begin
            unique case (state_q)
                ST1: begin
                    out_cw.rf1 = dec_cw.rf1;
                    out_cw.rf2 = dec_cw.rf2;
                    out_cw.en1 = dec_cw.en1;
                end
                ST2: begin
                    out_cw.s1  = cw_q.s1;
                    out_cw.s2  = cw_q.s2;
                    out_cw.alu = cw_q.alu;
                    out_cw.en2 = cw_q.en2;
                end
                ST3: begin
                    out_cw.rm  = cw_q.rm;
                    out_cw.wm  = cw_q.wm;
                    out_cw.en3 = cw_q.en3;
                    out_cw.s3  = cw_q.s3;
                    out_cw.wf1 = cw_q.wf1;
                end
                default: out_cw = '0;
            endcase
        end
    end

    assign rf1  = out_cw.rf1;
    assign rf2  = out_cw.rf2;
    assign en1  = out_cw.en1;
    assign s1   = out_cw.s1;
    assign s2   = out_cw.s2;
    assign alu1 = out_cw.alu[1];
    assign alu2 = out_cw.alu[0];
    assign en2  = out_cw.en2;
    assign rm   = out_cw.rm;
    assign wm   = out_cw.wm;
    assign en3  = out_cw.en3;
    assign s3   = out_cw.s3;
    assign wf1  = out_cw.wf1;

endmodule

// File: tb/tb_cu_fsm.sv
// Scoreboard bench for cu_fsm: each issued instruction pushes its three expected
// per-cycle output vectors; every cycle pops one and compares it with the outputs.
module tb_cu_fsm;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [10:0] func;
    logic rf1, rf2, en1, s1, s2, alu1, alu2, en2, rm, wm, en3, s3, wf1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [12:0] sb[$];

    localparam logic [12:0] M1 = 13'b111_00000_00000;
    localparam logic [12:0] M2 = 13'b000_11111_00000;
    localparam logic [12:0] M3 = 13'b000_00000_11111;

    cu_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func),
        .rf1(rf1), .rf2(rf2), .en1(en1), .s1(s1), .s2(s2),
        .alu1(alu1), .alu2(alu2), .en2(en2),
        .rm(rm), .wm(wm), .en3(en3), .s3(s3), .wf1(wf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %013b expected %013b", tag, got, exp);
        end
    endtask

    // Reference control word written straight from the decode table
    function automatic logic [12:0] ref_cw(input logic [5:0] op, input logic [10:0] fn);
        logic [12:0] cw;
        cw = 13'b0;
        case (op)
            6'h00: case (fn[5:0])
                6'h20: cw = 13'b110_0_0_00_1_00101;
                6'h22: cw = 13'b110_0_0_01_1_00101;
                6'h24: cw = 13'b110_0_0_10_1_00101;
                6'h25: cw = 13'b110_0_0_11_1_00101;
                default: cw = 13'b0;
            endcase
            6'h08: cw = 13'b100_0_1_00_1_00101;
            6'h0A: cw = 13'b100_0_1_01_1_00101;
            6'h0C: cw = 13'b100_0_1_10_1_00101;
            6'h0D: cw = 13'b100_0_1_11_1_00101;
            6'h23: cw = 13'b100_0_1_00_1_10111;
            6'h2B: cw = 13'b110_0_1_00_1_01100;
            default: cw = 13'b0;
        endcase
        return cw;
    endfunction

    // One clock: drive inputs after the falling edge, compare mid low phase
    task automatic tick(input string tag, input logic r, input logic [5:0] op, input logic [10:0] fn);
        logic [12:0] exp;
        rst    = r;
        opcode = op;
        func   = fn;
        #2;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %013b", tag,
                     {rf1, rf2, en1, s1, s2, alu1, alu2, en2, rm, wm, en3, s3, wf1});
        end else begin
            exp = sb.pop_front();
            check(tag, {rf1, rf2, en1, s1, s2, alu1, alu2, en2, rm, wm, en3, s3, wf1}, exp);
        end
        @(negedge clk);
    endtask

    // Issue one instruction; opcode/func are scrambled outside ST1 to show they are ignored
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [10:0] fn);
        logic [12:0] cw;
        cw = ref_cw(op, fn);
        sb.push_back(cw & M1);
        sb.push_back(cw & M2);
        sb.push_back(cw & M3);
        tick({tag, "_c0"}, 1'b0, op, fn);
        tick({tag, "_c1"}, 1'b0, 6'($urandom), 11'($urandom));
        tick({tag, "_c2"}, 1'b0, 6'($urandom), 11'($urandom));
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 6'h00;
        func   = 11'h020;
        @(negedge clk);

        // Reset held for three cycles with ADD on the inputs
        for (int i = 0; i < 3; i++) begin
            sb.push_back(13'b0);
            tick("reset", 1'b1, 6'h00, 11'h020);
        end

        run_instr("add",   6'h00, 11'h020);
        run_instr("sub",   6'h00, 11'h022);
        run_instr("and",   6'h00, 11'h024);
        run_instr("or",    6'h00, 11'h025);
        run_instr("addi",  6'h08, 11'h000);
        run_instr("subi",  6'h0A, 11'h000);
        run_instr("andi",  6'h0C, 11'h000);
        run_instr("ori",   6'h0D, 11'h000);
        run_instr("lw",    6'h23, 11'h000);
        run_instr("sw",    6'h2B, 11'h000);
        run_instr("nop",   6'h15, 11'h020);
        run_instr("unk3f", 6'h3F, 11'h020);
        run_instr("rf27",  6'h00, 11'h027);
        run_instr("add_hi", 6'h00, 11'h7A0);
        run_instr("ori2",  6'h0D, 11'h000);

        // Reset during ST2 of SUB aborts it: blank that cycle, then ST1 of the next instruction
        sb.push_back(ref_cw(6'h00, 11'h022) & M1);
        tick("abort_c0", 1'b0, 6'h00, 11'h022);
        sb.push_back(13'b0);
        tick("abort_rst", 1'b1, 6'h00, 11'h022);
        run_instr("after_abort", 6'h00, 11'h025);
        run_instr("lw2", 6'h23, 11'h000);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
